// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the single-cycle datapath.
// Latency: none, wires only.
// Backpressure: none; the sequencer paces the datapath through pc_en and the write enables.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic [31:0]      instr;
  logic [3:0]       status;
  logic [3:0]       opcode;
  logic             ALUsrc;
  logic             RegWrite;
  logic             MemRW;
  logic             MemtoReg;
  logic             PCsrc;
  logic             pc_en;
  logic             halted;
  logic             busy;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state_out;

  // Sequencer side: consumes run/instr/status, drives datapath controls.
  modport master (
    input  run, instr, status,
    output opcode, ALUsrc, RegWrite, MemRW, MemtoReg, PCsrc, pc_en,
           halted, busy, retired, state_out
  );

  // Datapath / debug side.
  modport slave (
    output run, instr, status,
    input  opcode, ALUsrc, RegWrite, MemRW, MemtoReg, PCsrc, pc_en,
           halted, busy, retired, state_out
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: latches each fetched instruction and steps it through FETCH/DECODE/EXEC/MEM/WB.
// Latency: R/I-ALU 4 cycles, LOAD 5, STORE 4, BRANCH 3; illegal opcodes park in HALT after 2 cycles.
// Backpressure: run is only looked at in IDLE and when an instruction ends; a dropped run lets the current one finish.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           reset,
  multicycle_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b0101;
  localparam logic [3:0] ALU_SRL = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  // Only the instruction fields the controller decodes are held; the rest belong to the datapath.
  logic [6:0]       ir_op;
  logic [2:0]       ir_f3;
  logic             ir_b30;
  logic [CNT_W-1:0] retired_q;

  logic             is_r, is_i, is_ld, is_st, is_br, legal;
  logic [3:0]       alu_op;
  logic             take;
  logic             last;
  logic             in_instr;
  logic             unused_bits;

  assign unused_bits = &{1'b0, bus.instr[31], bus.instr[29:15], bus.instr[11:7],
                         bus.status[3], bus.status[1:0]};

  assign is_r  = (ir_op == OP_R);
  assign is_i  = (ir_op == OP_I);
  assign is_ld = (ir_op == OP_LOAD);
  assign is_st = (ir_op == OP_STORE);
  assign is_br = (ir_op == OP_BRANCH);
  assign legal = is_r | is_i | is_ld | is_st | is_br;

  // ALU operation: memory ops address with ADD, branches compare with SUB, ALU ops decode funct3.
  always_comb begin
    alu_op = ALU_ADD;
    if (is_ld || is_st) begin
      alu_op = ALU_ADD;
    end else if (is_br) begin
      alu_op = ALU_SUB;
    end else if (is_r || is_i) begin
      case (ir_f3)
        3'b000:  alu_op = (is_r && ir_b30) ? ALU_SUB : ALU_ADD;
        3'b111:  alu_op = ALU_AND;
        3'b110:  alu_op = ALU_OR;
        3'b100:  alu_op = ALU_XOR;
        3'b001:  alu_op = ALU_SLL;
        3'b101:  alu_op = ALU_SRL;
        3'b010:  alu_op = ALU_SLT;
        default: alu_op = ALU_ADD;
      endcase
    end
  end

  // Branch decision from the ALU zero flag: BEQ takes on zero, BNE on non-zero.
  always_comb begin
    take = 1'b0;
    case (ir_f3)
      3'b000:  take = bus.status[2];
      3'b001:  take = ~bus.status[2];
      default: take = 1'b0;
    endcase
  end

  // The final state of each class is where the PC advances and the instruction retires.
  assign last = (state == S_WB) ||
                (state == S_MEM  && is_st) ||
                (state == S_EXEC && is_br);

  // Next-state sequencing per instruction class.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = bus.run ? S_FETCH : S_IDLE;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_br)              state_nxt = bus.run ? S_FETCH : S_IDLE;
        else if (is_ld || is_st) state_nxt = S_MEM;
        else                    state_nxt = S_WB;
      end
      S_MEM: begin
        if (is_st) state_nxt = bus.run ? S_FETCH : S_IDLE;
        else       state_nxt = S_WB;
      end
      S_WB:     state_nxt = bus.run ? S_FETCH : S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // State, instruction register and retired counter; reset clears them without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ir_op     <= '0;
      ir_f3     <= '0;
      ir_b30    <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        ir_op  <= bus.instr[6:0];
        ir_f3  <= bus.instr[14:12];
        ir_b30 <= bus.instr[30];
      end
      if (last) begin
        retired_q <= retired_q + 1'b1;
      end
    end
  end

  // DECODE onward is where the decoded ALU controls are held; illegal ops decode to zeros.
  assign in_instr = (state == S_DECODE) || (state == S_EXEC) ||
                    (state == S_MEM)    || (state == S_WB);

  // Moore outputs decoded from state and the latched instruction.
  always_comb begin
    bus.opcode    = in_instr ? alu_op : 4'b0000;
    bus.ALUsrc    = in_instr && (is_i || is_ld || is_st);
    bus.RegWrite  = (state == S_WB);
    bus.MemRW     = (state == S_MEM) && is_st;
    bus.MemtoReg  = is_ld && ((state == S_MEM) || (state == S_WB));
    bus.pc_en     = last;
    bus.PCsrc     = (state == S_EXEC) && is_br && take;
    bus.halted    = (state == S_HALT);
    bus.busy      = (state != S_IDLE) && (state != S_HALT);
    bus.state_out = state;
    bus.retired   = retired_q;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for the multi-cycle sequencer: one full-width instance plus a 4-bit-counter instance.
// Latency: inputs change and outputs are sampled on the falling edge, half a cycle from the active edge.
// Backpressure: n/a; run is driven directly as a start/stop level.
module tb_multicycle_ctrl;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h0040A183;
  localparam logic [31:0] I_SW   = 32'h0030A223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_XORI = 32'h0040C093;
  localparam logic [31:0] I_ILL  = 32'h0000007F;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(16)) bus_a ();
  multicycle_ctrl_if #(.CNT_W(4))  bus_b ();

  multicycle_ctrl #(.CNT_W(16)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  multicycle_ctrl #(.CNT_W(4))  dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  // Packs {opcode, ALUsrc, RegWrite, MemRW, MemtoReg, PCsrc, pc_en, halted, busy}.
  function automatic logic [11:0] ctl(input logic [3:0] op, input logic as, input logic rw,
                                      input logic mw, input logic m2r, input logic pcs,
                                      input logic pce, input logic h, input logic b);
    return {op, as, rw, mw, m2r, pcs, pce, h, b};
  endfunction

  function automatic logic [11:0] obs_a();
    return {bus_a.opcode, bus_a.ALUsrc, bus_a.RegWrite, bus_a.MemRW, bus_a.MemtoReg,
            bus_a.PCsrc, bus_a.pc_en, bus_a.halted, bus_a.busy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // Advance one cycle and check dut_a's state and control vector.
  task automatic step(input string tag, input logic [2:0] st, input logic [11:0] c);
    @(negedge clk);
    chk({tag, ".state"}, {29'd0, bus_a.state_out}, {29'd0, st});
    chk({tag, ".ctl"},   {20'd0, obs_a()},         {20'd0, c});
  endtask

  initial begin
    logic [11:0] busy_only;
    logic [11:0] halt_c;
    busy_only = ctl(4'd0, 0, 0, 0, 0, 0, 0, 0, 1);
    halt_c    = ctl(4'd0, 0, 0, 0, 0, 0, 0, 1, 0);

    reset        = 1'b1;
    bus_a.run    = 1'b0;
    bus_a.instr  = 32'd0;
    bus_a.status = 4'd0;
    bus_b.run    = 1'b0;
    bus_b.instr  = I_ADD;
    bus_b.status = 4'd0;

    // Reset state.
    @(negedge clk);
    chk("rst.state",   {29'd0, bus_a.state_out}, 32'd0);
    chk("rst.ctl",     {20'd0, obs_a()},         32'd0);
    chk("rst.retired", {16'd0, bus_a.retired},   32'd0);
    reset = 1'b0;
    step("idle0", 3'd0, 12'd0);

    // Single ADD.
    bus_a.run   = 1'b1;
    bus_a.instr = I_ADD;
    step("add.f", 3'd1, busy_only);
    step("add.d", 3'd2, ctl(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
    step("add.e", 3'd3, ctl(4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
    step("add.w", 3'd5, ctl(4'b0000, 0, 1, 0, 0, 0, 1, 0, 1));
    bus_a.instr = I_LW;

    // LOAD: five cycles, MemtoReg in MEM and WB.
    step("lw.f", 3'd1, busy_only);
    chk("add.retired", {16'd0, bus_a.retired}, 32'd1);
    step("lw.d", 3'd2, ctl(4'b0000, 1, 0, 0, 0, 0, 0, 0, 1));
    step("lw.e", 3'd3, ctl(4'b0000, 1, 0, 0, 0, 0, 0, 0, 1));
    step("lw.m", 3'd4, ctl(4'b0000, 1, 0, 0, 1, 0, 0, 0, 1));
    step("lw.w", 3'd5, ctl(4'b0000, 1, 1, 0, 1, 0, 1, 0, 1));
    bus_a.instr = I_SW;

    // STORE: MemRW and pc_en only in MEM, no RegWrite.
    step("sw.f", 3'd1, busy_only);
    step("sw.d", 3'd2, ctl(4'b0000, 1, 0, 0, 0, 0, 0, 0, 1));
    step("sw.e", 3'd3, ctl(4'b0000, 1, 0, 0, 0, 0, 0, 0, 1));
    step("sw.m", 3'd4, ctl(4'b0000, 1, 0, 1, 0, 0, 1, 0, 1));
    bus_a.instr  = I_BEQ;
    bus_a.status = 4'b0100;

    // BEQ taken.
    step("beq1.f", 3'd1, busy_only);
    chk("sw.retired", {16'd0, bus_a.retired}, 32'd3);
    step("beq1.d", 3'd2, ctl(4'b0001, 0, 0, 0, 0, 0, 0, 0, 1));
    step("beq1.e", 3'd3, ctl(4'b0001, 0, 0, 0, 0, 1, 1, 0, 1));
    bus_a.status = 4'b0000;

    // BEQ not taken.
    step("beq0.f", 3'd1, busy_only);
    step("beq0.d", 3'd2, ctl(4'b0001, 0, 0, 0, 0, 0, 0, 0, 1));
    step("beq0.e", 3'd3, ctl(4'b0001, 0, 0, 0, 0, 0, 1, 0, 1));
    bus_a.instr = I_BNE;

    // BNE with zero flag clear: taken.
    step("bne.f", 3'd1, busy_only);
    step("bne.d", 3'd2, ctl(4'b0001, 0, 0, 0, 0, 0, 0, 0, 1));
    step("bne.e", 3'd3, ctl(4'b0001, 0, 0, 0, 0, 1, 1, 0, 1));
    bus_a.instr = I_XORI;

    // XORI: I-type ALU op uses the immediate.
    step("xori.f", 3'd1, busy_only);
    step("xori.d", 3'd2, ctl(4'b0100, 1, 0, 0, 0, 0, 0, 0, 1));
    step("xori.e", 3'd3, ctl(4'b0100, 1, 0, 0, 0, 0, 0, 0, 1));
    step("xori.w", 3'd5, ctl(4'b0100, 1, 1, 0, 0, 0, 1, 0, 1));
    bus_a.instr = I_SUB;

    // SUB with run dropped in EXEC: WB still happens, then IDLE.
    step("sub.f", 3'd1, busy_only);
    step("sub.d", 3'd2, ctl(4'b0001, 0, 0, 0, 0, 0, 0, 0, 1));
    step("sub.e", 3'd3, ctl(4'b0001, 0, 0, 0, 0, 0, 0, 0, 1));
    bus_a.run = 1'b0;
    step("sub.w", 3'd5, ctl(4'b0001, 0, 1, 0, 0, 0, 1, 0, 1));
    step("sub.idle", 3'd0, 12'd0);
    chk("sub.retired", {16'd0, bus_a.retired}, 32'd8);
    step("idle1", 3'd0, 12'd0);
    bus_a.run   = 1'b1;
    bus_a.instr = I_ILL;

    // Illegal opcode: resume straight into FETCH, then park in HALT.
    step("ill.f", 3'd1, busy_only);
    step("ill.d", 3'd2, busy_only);
    for (int i = 0; i < 20; i++) begin
      step("ill.halt", 3'd6, halt_c);
    end
    chk("ill.retired", {16'd0, bus_a.retired}, 32'd8);

    // Reset leaves HALT asynchronously.
    bus_a.run = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("haltrst.state",   {29'd0, bus_a.state_out}, 32'd0);
    chk("haltrst.ctl",     {20'd0, obs_a()},         32'd0);
    chk("haltrst.retired", {16'd0, bus_a.retired},   32'd0);
    @(negedge clk);
    reset = 1'b0;
    step("idle2", 3'd0, 12'd0);

    // Reset pulsed mid-MEM of a LOAD: outputs drop before the next edge.
    bus_a.run   = 1'b1;
    bus_a.instr = I_LW;
    step("lw2.f", 3'd1, busy_only);
    step("lw2.d", 3'd2, ctl(4'b0000, 1, 0, 0, 0, 0, 0, 0, 1));
    step("lw2.e", 3'd3, ctl(4'b0000, 1, 0, 0, 0, 0, 0, 0, 1));
    step("lw2.m", 3'd4, ctl(4'b0000, 1, 0, 0, 1, 0, 0, 0, 1));
    #2 reset = 1'b1;
    #1;
    chk("memrst.state", {29'd0, bus_a.state_out}, 32'd0);
    chk("memrst.ctl",   {20'd0, obs_a()},         32'd0);
    bus_a.run = 1'b0;
    @(negedge clk);
    chk("memrst.hold", {20'd0, obs_a()}, 32'd0);
    reset = 1'b0;
    step("idle3", 3'd0, 12'd0);

    // Counter wrap on the 4-bit instance: 16 ADDs wrap to 0, the 17th gives 1.
    bus_b.run = 1'b1;
    repeat (65) @(negedge clk);
    chk("wrap16.state",   {29'd0, bus_b.state_out}, 32'd1);
    chk("wrap16.retired", {28'd0, bus_b.retired},   32'd0);
    repeat (3) @(negedge clk);
    chk("wrap17.wb", {29'd0, bus_b.state_out}, 32'd5);
    bus_b.run = 1'b0;
    @(negedge clk);
    chk("wrap17.state",   {29'd0, bus_b.state_out}, 32'd0);
    chk("wrap17.retired", {28'd0, bus_b.retired},   32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit that sequences the single-cycle datapath (PC, ROM, register file, ALU, RAM, PC mux) one instruction at a time. It drives the datapath control inputs and a new PC write enable.

- Fetched instructions are latched and classified (RISC-V-style opcode field).
- Each instruction steps through FETCH/DECODE/EXEC/MEM/WB states, and register and RAM writes are gated to exactly one cycle.
- It also provides run/halt control and a retired-instruction counter for debug.

## Interface
- `CNT_W`, default 16: width of retired-instruction counter.
- `clk` in 1: system clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-high. Forces the block to IDLE and all registers to 0.
- `run` in 1: start/continue. Sampled only in IDLE and on entry to FETCH.
- `instr` in 32: ROM output at the current PC.
- `status` in 4: ALU status flags; `status[2]` = zero flag.
- `opcode` out 4: ALU operation select.
- `ALUsrc` out 1: 0 = rs2, 1 = immediate.
- `RegWrite` out 1: register file write enable.
- `MemRW` out 1: 1 = RAM write, 0 = read.
- `MemtoReg` out 1: 1 = RAM data to register writeback.
- `PCsrc` out 1: 0 = PC+4, 1 = PC+imm.
- `pc_en` out 1: PC register load enable.
- `halted` out 1: set on an illegal opcode.
- `busy` out 1: high in any state other than IDLE or HALT.
- `retired` out `CNT_W`: count of completed instructions.
- `state_out` out 3: current state encoding.

## Operation
- **State encoding:** IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- **Instruction register:** `ir` loads `instr` at the end of FETCH. All decode uses `ir`, never live `instr`.
- **Classes by `ir[6:0]`:**
  - R = 0110011
  - I-ALU = 0010011
  - LOAD = 0000011
  - STORE = 0100011
  - BRANCH = 1100011
  - Any other value is illegal.
- **ALU opcode from `funct3=ir[14:12]`:**
  - 000: ADD=0000, or SUB=0001 when R-type and `ir[30]`=1
  - 111: AND=0010
  - 110: OR=0011
  - 100: XOR=0100
  - 001: SLL=0101
  - 101: SRL=0110
  - 010: SLT=0111
- **ALU opcode by class:** LOAD and STORE force ADD. BRANCH forces SUB.
- **ALUsrc by class:** 1 for I-ALU, LOAD and STORE; 0 for R and BRANCH.
- **Hold rule:** `opcode` and `ALUsrc` are valid from DECODE through the last state of the instruction. They are 0 in IDLE, FETCH and HALT.
- **State sequences by class:**
  - R and I-ALU: FETCH → DECODE → EXEC → WB. `RegWrite`=1 and `pc_en`=1 in WB.
  - LOAD: FETCH → DECODE → EXEC → MEM → WB. `MemtoReg`=1 in MEM and WB. `RegWrite`=1 and `pc_en`=1 in WB.
  - STORE: FETCH → DECODE → EXEC → MEM. `MemRW`=1 and `pc_en`=1 in MEM.
  - BRANCH: FETCH → DECODE → EXEC. `pc_en`=1 in EXEC.
- **Branch decision:** `take` = `status[2]` for funct3=000 (BEQ), `~status[2]` for funct3=001 (BNE), 0 otherwise. `PCsrc`=`take`, valid only while `pc_en`=1; otherwise `PCsrc`=0.
- **Illegal opcode:** DECODE → HALT. `halted`=1 and all enables are 0. HALT is left only by `reset`.
- **After the last state of an instruction:**
  - `retired` increments by 1, wrapping modulo 2^`CNT_W`.
  - The block goes to FETCH if `run`=1, else IDLE.
- **IDLE:** goes to FETCH when `run`=1.
- **run dropped mid-instruction:** the current instruction completes normally; `run` is not checked until the instruction ends.
- **Outside their listed states,** `RegWrite`, `MemRW`, `MemtoReg` and `pc_en` are 0.

## Timing
- **Reset values:** all outputs 0, `state_out`=0, `ir`=0. `reset` asserted mid-instruction aborts it with no further write enables.
- **Output type:** outputs are Moore, decoded from state and `ir`, so they are valid in the same cycle the state is entered.
- **Cycles per instruction:** R/I-ALU 4, LOAD 5, STORE 4, BRANCH 3. Illegal reaches HALT after 2 cycles.
- **Enable pulse width:** each of `pc_en`, `RegWrite` and `MemRW` is exactly one cycle per instruction. The datapath writes on the same rising edge that leaves the state.
- **First fetch after reset:** FETCH is entered one cycle after `run`=1 is sampled in IDLE.

## Test plan
- **Single ADD:** reset, `run`=1, `instr`=0x002081B3.
  - States go 1, 2, 3, 5, then 1.
  - `opcode`=0000 and `ALUsrc`=0.
  - `RegWrite` and `pc_en` are high only in WB.
  - `retired`=1.
- **LOAD then STORE:** `instr`=0x0040A183, then 0x0030A223.
  - LOAD takes 5 cycles with `MemtoReg`=1 in MEM and WB.
  - STORE has `MemRW`=1 for exactly one cycle in MEM and never asserts `RegWrite`.
  - `retired`=2.
- **BEQ taken and not taken:** `instr`=0x00208463.
  - With `status`=4'b0100: `pc_en`=1 and `PCsrc`=1 in EXEC.
  - With `status`=0: `PCsrc`=0.
  - 3 cycles each.
- **Illegal opcode:** `ir[6:0]`=1111111.
  - HALT is reached after DECODE with `halted`=1 and no enables.
  - It persists for 20 cycles with `run`=1.
  - `reset` clears it.
- **run dropped:** `run` falls during EXEC of SUB (0x402081B3).
  - WB still occurs, then IDLE.
  - `run`=1 resumes at FETCH on the next cycle.
- **Async reset and counter wrap:**
  - `reset` pulsed mid-MEM: all outputs 0 immediately, without waiting for an edge.
  - With `CNT_W`=4 and 17 ADDs: `retired`=1.
